l1_data_ldst_align: RTL and testbench

- Load/store front-end that sits directly upstream of the L1 data cache, between the execute stage and the cache's LDST request port.
- Accepts one execute-stage memory command at a time and checks its alignment.
- Positions store data into byte lanes, issues the request to the cache, and holds it until the cache accepts.
- Waits for the cache/IO result, then extracts and extends the load value and returns it to writeback.

---
 rtl/l1_data_ldst_align.sv | 192 +++++++++++++++++++
 tb/tb_l1_data_ldst_align.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_data_ldst_align.sv
`default_nettype none
// ============================================================================
// Module   : l1_data_ldst_align
// Purpose  : Load/store front-end for the L1 data cache. Checks the alignment
//            of one execute command, places store data in its byte lanes,
//            holds the cache request until it is accepted, then extracts and
//            extends the load result for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module l1_data_ldst_align #(
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32   // lane logic assumes exactly 4 byte lanes
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iREMOVE,
  input  logic                iEXE_REQ,
  output logic                oEXE_BUSY,
  input  logic [1:0]          iEXE_ORDER,
  input  logic                iEXE_RW,
  input  logic                iEXE_SIGNED,
  input  logic [31:0]         iEXE_TID,
  input  logic [1:0]          iEXE_MMUMOD,
  input  logic [31:0]         iEXE_PDT,
  input  logic [P_ADDR_W-1:0] iEXE_ADDR,
  input  logic [P_DATA_W-1:0] iEXE_DATA,
  output logic                oLDST_REQ,
  input  logic                iLDST_BUSY,
  output logic [1:0]          oLDST_ORDER,
  output logic                oLDST_RW,
  output logic [31:0]         oLDST_TID,
  output logic [1:0]          oLDST_MMUMOD,
  output logic [31:0]         oLDST_PDT,
  output logic [P_ADDR_W-1:0] oLDST_ADDR,
  output logic [P_DATA_W-1:0] oLDST_DATA,
  input  logic                iLDST_VALID,
  input  logic [P_DATA_W-1:0] iLDST_DATA,
  output logic                oWB_VALID,
  output logic                oWB_RW,
  output logic                oWB_FAULT,
  output logic [P_DATA_W-1:0] oWB_DATA
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          order_q;
  logic                rw_q;
  logic                signed_q;
  logic [31:0]         tid_q;
  logic [1:0]          mmumod_q;
  logic [31:0]         pdt_q;
  logic [P_ADDR_W-1:0] addr_q;
  logic [P_DATA_W-1:0] lanes_q;
  logic                wb_rw_q;
  logic                wb_fault_q;
  logic [P_DATA_W-1:0] wb_data_q;

  logic                misaligned;
  logic [P_DATA_W-1:0] store_lanes;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [P_DATA_W-1:0] load_ext;

  // Alignment check of the incoming command; order 3 is always illegal.
  always_comb begin
    misaligned = 1'b0;
    case (iEXE_ORDER)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = iEXE_ADDR[0];
      2'd2:    misaligned = (iEXE_ADDR[1:0] != 2'd0);
      default: misaligned = 1'b1;
    endcase
  end

  // Shift right-justified store data into its byte lanes, unused lanes zero.
  always_comb begin
    store_lanes = '0;
    case (iEXE_ORDER)
      2'd0:    store_lanes = {24'd0, iEXE_DATA[7:0]} << {iEXE_ADDR[1:0], 3'b000};
      2'd1:    store_lanes = {16'd0, iEXE_DATA[15:0]} << {iEXE_ADDR[1], 4'b0000};
      default: store_lanes = iEXE_DATA;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    ld_byte  = 8'd0;
    case (addr_q[1:0])
      2'd0:    ld_byte = iLDST_DATA[7:0];
      2'd1:    ld_byte = iLDST_DATA[15:8];
      2'd2:    ld_byte = iLDST_DATA[23:16];
      default: ld_byte = iLDST_DATA[31:24];
    endcase
    ld_half  = addr_q[1] ? iLDST_DATA[31:16] : iLDST_DATA[15:0];
    load_ext = iLDST_DATA;
    case (order_q)
      2'd0:    load_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_ext = iLDST_DATA;
    endcase
  end

  // Command FSM: latch, request, wait for completion, report, or drain on flush.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state      <= S_IDLE;
      order_q    <= 2'd0;
      rw_q       <= 1'b0;
      signed_q   <= 1'b0;
      tid_q      <= 32'd0;
      mmumod_q   <= 2'd0;
      pdt_q      <= 32'd0;
      addr_q     <= '0;
      lanes_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_fault_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!iREMOVE && iEXE_REQ) begin
            order_q  <= iEXE_ORDER;
            rw_q     <= iEXE_RW;
            signed_q <= iEXE_SIGNED;
            tid_q    <= iEXE_TID;
            mmumod_q <= iEXE_MMUMOD;
            pdt_q    <= iEXE_PDT;
            addr_q   <= iEXE_ADDR;
            lanes_q  <= store_lanes;
            if (misaligned) begin
              // Faulting command never reaches the cache.
              wb_rw_q    <= iEXE_RW;
              wb_fault_q <= 1'b1;
              wb_data_q  <= '0;
              state      <= S_DONE;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Completions arriving before acceptance are not ours; ignore them.
          if (iREMOVE)          state <= S_IDLE;
          else if (!iLDST_BUSY) state <= S_WAIT;
        end
        S_WAIT: begin
          if (iREMOVE) begin
            // A response in the flush cycle is the one we would have drained.
            state <= iLDST_VALID ? S_IDLE : S_DRAIN;
          end else if (iLDST_VALID) begin
            wb_rw_q    <= rw_q;
            wb_fault_q <= 1'b0;
            wb_data_q  <= rw_q ? load_ext : '0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (iLDST_VALID) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign oEXE_BUSY    = (state != S_IDLE);
  assign oLDST_REQ    = (state == S_REQ) & ~iREMOVE;
  assign oLDST_ORDER  = order_q;
  assign oLDST_RW     = rw_q;
  assign oLDST_TID    = tid_q;
  assign oLDST_MMUMOD = mmumod_q;
  assign oLDST_PDT    = pdt_q;
  assign oLDST_ADDR   = addr_q;
  assign oLDST_DATA   = lanes_q;
  assign oWB_VALID    = (state == S_DONE) & ~iREMOVE;
  assign oWB_RW       = wb_rw_q;
  assign oWB_FAULT    = wb_fault_q;
  assign oWB_DATA     = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_data_ldst_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_data_ldst_align
// Purpose  : Self-checking bench for l1_data_ldst_align. Table of commands with
//            expected lanes/results, a writeback scoreboard, and hand-written
//            flush/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_data_ldst_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        remove, exe_req, exe_busy, exe_rw, exe_signed;
  logic [1:0]  exe_order, exe_mmumod;
  logic [31:0] exe_tid, exe_pdt, exe_addr, exe_data;
  logic        ldst_req, ldst_busy, ldst_rw, ldst_valid;
  logic [1:0]  ldst_order, ldst_mmumod;
  logic [31:0] ldst_tid, ldst_pdt, ldst_addr, ldst_data, ldst_rdata;
  logic        wb_valid, wb_rw, wb_fault;
  logic [31:0] wb_data;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  order;
    logic        rw;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    int          busy_cyc;
    logic [31:0] ret;
    logic        fault;
    logic [31:0] exp_lanes;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic        rw;
    logic        fault;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[13];
  wb_t  exp_q[$];

  always #5 clk = ~clk;

  l1_data_ldst_align #(.P_ADDR_W(32), .P_DATA_W(32)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(remove),
    .iEXE_REQ(exe_req), .oEXE_BUSY(exe_busy), .iEXE_ORDER(exe_order),
    .iEXE_RW(exe_rw), .iEXE_SIGNED(exe_signed), .iEXE_TID(exe_tid),
    .iEXE_MMUMOD(exe_mmumod), .iEXE_PDT(exe_pdt), .iEXE_ADDR(exe_addr),
    .iEXE_DATA(exe_data), .oLDST_REQ(ldst_req), .iLDST_BUSY(ldst_busy),
    .oLDST_ORDER(ldst_order), .oLDST_RW(ldst_rw), .oLDST_TID(ldst_tid),
    .oLDST_MMUMOD(ldst_mmumod), .oLDST_PDT(ldst_pdt), .oLDST_ADDR(ldst_addr),
    .oLDST_DATA(ldst_data), .iLDST_VALID(ldst_valid), .iLDST_DATA(ldst_rdata),
    .oWB_VALID(wb_valid), .oWB_RW(wb_rw), .oWB_FAULT(wb_fault), .oWB_DATA(wb_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every writeback pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 32'(wb_valid), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rw", 32'(wb_rw), 32'(e.rw));
        chk("wb_fault", 32'(wb_fault), 32'(e.fault));
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_cmd(input logic [1:0] order, input logic rw, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] data);
    exe_req    = 1'b1;
    exe_order  = order;
    exe_rw     = rw;
    exe_signed = sgn;
    exe_addr   = addr;
    exe_data   = data;
    exe_tid    = addr ^ 32'hA5A5_0000;
    exe_pdt    = ~addr;
    exe_mmumod = addr[3:2];
  endtask

  task automatic apply(input vec_t v);
    wb_t e;
    @(posedge clk); #1;
    drive_cmd(v.order, v.rw, v.sgn, v.addr, v.data);
    e.rw = v.rw; e.fault = v.fault; e.data = v.exp_wb;
    exp_q.push_back(e);
    @(posedge clk); #1;
    exe_req = 1'b0;
    if (v.fault) begin
      @(negedge clk);
      chk("fault_no_req", 32'(ldst_req), 32'd0);
      chk("fault_wb_valid", 32'(wb_valid), 32'd1);
    end else begin
      for (int k = 0; k <= v.busy_cyc; k++) begin
        ldst_busy  = (k < v.busy_cyc);
        ldst_valid = (k < v.busy_cyc);   // completions during REQ must be ignored
        ldst_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("ldst_req", 32'(ldst_req), 32'd1);
        chk("ldst_lanes", ldst_data, v.exp_lanes);
        chk("ldst_addr", ldst_addr, v.addr);
        if (k == 0) begin
          chk("ldst_order", 32'(ldst_order), 32'(v.order));
          chk("ldst_rw", 32'(ldst_rw), 32'(v.rw));
          chk("ldst_tid", ldst_tid, v.addr ^ 32'hA5A5_0000);
          chk("ldst_pdt", ldst_pdt, ~v.addr);
          chk("ldst_mmumod", 32'(ldst_mmumod), 32'(v.addr[3:2]));
        end
        @(posedge clk); #1;
      end
      ldst_busy  = 1'b0;
      ldst_valid = 1'b1;
      ldst_rdata = v.ret;
      @(negedge clk);
      chk("wait_no_req", 32'(ldst_req), 32'd0);
      chk("wait_busy", 32'(exe_busy), 32'd1);
      @(posedge clk); #1;
      ldst_valid = 1'b0;
      @(negedge clk);
      chk("wb_valid_latency", 32'(wb_valid), 32'd1);
    end
    @(posedge clk); #1;
    chk("idle_busy", 32'(exe_busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    //           order rw  sgn addr          data          busy ret           fault lanes         wb
    vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'h0000_0103, 32'h0000_0000, 0, 32'h80FF_1234, 1'b0, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[1]  = '{2'd1, 1'b0, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 4, 32'hFFFF_FFFF, 1'b0, 32'hBEEF_0000, 32'h0000_0000};
    vecs[2]  = '{2'd2, 1'b1, 1'b0, 32'h0000_0105, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{2'd3, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{2'd1, 1'b1, 1'b0, 32'h0000_0302, 32'h0000_0000, 0, 32'h9ABC_5678, 1'b0, 32'h0000_0000, 32'h0000_9ABC};
    vecs[5]  = '{2'd0, 1'b0, 1'b0, 32'h0000_0041, 32'h1234_56AB, 2, 32'hFFFF_FFFF, 1'b0, 32'h0000_AB00, 32'h0000_0000};
    vecs[6]  = '{2'd2, 1'b0, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7]  = '{2'd1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 0, 32'h1234_8001, 1'b0, 32'h0000_0000, 32'hFFFF_8001};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 0, 32'hAABB_CCDD, 1'b0, 32'h0000_0000, 32'h0000_00CC};
    vecs[9]  = '{2'd1, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_1111, 0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{2'd2, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[11] = '{2'd0, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0000, 0, 32'h007F_0000, 1'b0, 32'h0000_0000, 32'h0000_007F};
    vecs[12] = '{2'd1, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_1357, 1, 32'hFFFF_FFFF, 1'b0, 32'h0000_1357, 32'h0000_0000};

    rst_n = 1'b0; remove = 1'b0; ldst_busy = 1'b0; ldst_valid = 1'b0; ldst_rdata = '0;
    drive_cmd(2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    exe_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(exe_busy), 32'd0);
    chk("rst_req", 32'(ldst_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_fault", 32'(wb_fault), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ldst_addr", ldst_addr, 32'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Flush in WAIT, a second flush in DRAIN, response two cycles later
    @(posedge clk); #1;
    drive_cmd(2'd2, 1'b1, 1'b0, 32'h0000_0400, 32'd0);
    @(posedge clk); #1; exe_req = 1'b0;          // REQ, accepted
    @(posedge clk); #1; remove = 1'b1;           // WAIT
    @(negedge clk);
    chk("flush_wait_busy", 32'(exe_busy), 32'd1);
    @(posedge clk); #1;                          // DRAIN, flush still held
    @(negedge clk);
    chk("drain_busy0", 32'(exe_busy), 32'd1);
    @(posedge clk); #1; remove = 1'b0; ldst_valid = 1'b1; ldst_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("drain_busy1", 32'(exe_busy), 32'd1);
    chk("drain_no_wb", 32'(wb_valid), 32'd0);
    @(posedge clk); #1; ldst_valid = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(exe_busy), 32'd0);
    chk("drain_no_wb2", 32'(wb_valid), 32'd0);
    apply(vecs[4]);

    // Flush in REQ suppresses the request in the same cycle
    @(posedge clk); #1;
    drive_cmd(2'd0, 1'b1, 1'b0, 32'h0000_0500, 32'd0);
    @(posedge clk); #1; exe_req = 1'b0; ldst_busy = 1'b1;
    @(negedge clk);
    chk("req_before_flush", 32'(ldst_req), 32'd1);
    @(posedge clk); #1; remove = 1'b1;
    #1 chk("req_flush_suppress", 32'(ldst_req), 32'd0);
    @(posedge clk); #1; remove = 1'b0; ldst_busy = 1'b0;
    @(negedge clk);
    chk("req_flush_idle", 32'(exe_busy), 32'd0);

    // Command presented together with a flush in IDLE is not accepted
    @(posedge clk); #1;
    drive_cmd(2'd2, 1'b1, 1'b0, 32'h0000_0600, 32'd0);
    remove = 1'b1;
    @(posedge clk); #1; exe_req = 1'b0; remove = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 32'(exe_busy), 32'd0);
    chk("idle_flush_req", 32'(ldst_req), 32'd0);

    // Flush in DONE suppresses the writeback pulse
    @(posedge clk); #1;
    drive_cmd(2'd3, 1'b1, 1'b0, 32'h0000_0700, 32'd0);
    @(posedge clk); #1; exe_req = 1'b0; remove = 1'b1;
    @(negedge clk);
    chk("done_flush_busy", 32'(exe_busy), 32'd1);
    chk("done_flush_no_wb", 32'(wb_valid), 32'd0);
    @(posedge clk); #1; remove = 1'b0;
    @(negedge clk);
    chk("done_flush_idle", 32'(exe_busy), 32'd0);

    // Response and flush in the same WAIT cycle: straight back to IDLE
    @(posedge clk); #1;
    drive_cmd(2'd2, 1'b1, 1'b0, 32'h0000_0800, 32'd0);
    @(posedge clk); #1; exe_req = 1'b0;
    @(posedge clk); #1; remove = 1'b1; ldst_valid = 1'b1; ldst_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("simul_no_wb", 32'(wb_valid), 32'd0);
    @(posedge clk); #1; remove = 1'b0; ldst_valid = 1'b0;
    @(negedge clk);
    chk("simul_idle", 32'(exe_busy), 32'd0);

    // Reset asserted in WAIT clears outputs immediately; late response ignored
    @(posedge clk); #1;
    drive_cmd(2'd1, 1'b1, 1'b1, 32'h0000_0902, 32'd0);
    @(posedge clk); #1; exe_req = 1'b0;
    @(posedge clk); #1;
    chk("rstwait_busy", 32'(exe_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwait_busy0", 32'(exe_busy), 32'd0);
    chk("rstwait_req0", 32'(ldst_req), 32'd0);
    chk("rstwait_addr0", ldst_addr, 32'd0);
    chk("rstwait_tid0", ldst_tid, 32'd0);
    chk("rstwait_wbdata0", wb_data, 32'd0);
    chk("rstwait_fault0", 32'(wb_fault), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; ldst_valid = 1'b1; ldst_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_valid_busy", 32'(exe_busy), 32'd0);
    @(posedge clk); #1; ldst_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_no_wb", 32'(wb_valid), 32'd0);
    chk("late_valid_idle", 32'(exe_busy), 32'd0);
    apply(vecs[0]);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
